// File: rtl/exec_unit_if.sv
// Request/response bundle between the issue logic and exec_unit.
// The master drives the operation request; the slave (exec_unit) returns the write-back.
interface exec_unit_if;
  logic        start;
  logic [2:0]  aluk;
  logic [15:0] Ra;
  logic [15:0] Rb;
  logic [15:0] imm;
  logic        selImm;
  logic [2:0]  DRin;
  logic [15:0] result;
  logic        regWE;
  logic [2:0]  DR;
  logic        busy;
  logic [2:0]  nzp;

  modport master (
    output start, aluk, Ra, Rb, imm, selImm, DRin,
    input  result, regWE, DR, busy, nzp
  );

  modport slave (
    input  start, aluk, Ra, Rb, imm, selImm, DRin,
    output result, regWE, DR, busy, nzp
  );
endinterface

// File: rtl/exec_unit.sv
// Multi-cycle ALU: ADD/AND/NOT/PASSA in one execute cycle, optional 16-cycle shift-add MUL.
// Define EXEC_UNIT_MUL_EN to build the MUL state and multiplier; otherwise aluk 100 runs as PASSA.
module exec_unit (
  input  logic         clk,
  input  logic         reset,
  exec_unit_if.slave   bus
);

  localparam logic [2:0] OP_ADD   = 3'b000;
  localparam logic [2:0] OP_AND   = 3'b001;
  localparam logic [2:0] OP_NOT   = 3'b010;
  localparam logic [2:0] OP_PASSA = 3'b011;

`ifdef EXEC_UNIT_MUL_EN
  localparam logic [2:0] OP_MUL   = 3'b100;
  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_MUL, S_DONE} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_DONE} state_t;
`endif

  state_t      state;
  logic [15:0] a_q;
  logic [15:0] b_q;
  logic [2:0]  op_q;
  logic [2:0]  dr_q;
  logic [15:0] alu_y;

  function automatic logic [2:0] cond_codes(input logic [15:0] v);
    if (v[15])          return 3'b100;
    else if (v == 16'h0) return 3'b010;
    else                return 3'b001;
  endfunction

  // Reserved opcodes (and MUL when the multiplier is not built) fall through to PASSA.
  always_comb begin
    alu_y = a_q;
    case (op_q)
      OP_ADD:   alu_y = a_q + b_q;
      OP_AND:   alu_y = a_q & b_q;
      OP_NOT:   alu_y = ~a_q;
      OP_PASSA: alu_y = a_q;
      default:  alu_y = a_q;
    endcase
  end

`ifdef EXEC_UNIT_MUL_EN
  // a_q shifts left as the multiplicand, b_q shifts right so b_q[0] is the current multiplier bit.
  logic [15:0] acc;
  logic [3:0]  cnt;
  logic [15:0] mul_sum;

  always_comb begin
    mul_sum = acc + (b_q[0] ? a_q : 16'h0000);
  end
`endif

  // NOTE: all sequential state is updated with non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      a_q        <= 16'h0000;
      b_q        <= 16'h0000;
      op_q       <= 3'b000;
      dr_q       <= 3'b000;
      bus.result <= 16'h0000;
      bus.regWE  <= 1'b0;
      bus.DR     <= 3'b000;
      bus.busy   <= 1'b0;
      bus.nzp    <= 3'b010;
`ifdef EXEC_UNIT_MUL_EN
      acc        <= 16'h0000;
      cnt        <= 4'd0;
`endif
    end else begin
      bus.regWE <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            a_q      <= bus.Ra;
            b_q      <= bus.selImm ? bus.imm : bus.Rb;
            op_q     <= bus.aluk;
            dr_q     <= bus.DRin;
            bus.busy <= 1'b1;
`ifdef EXEC_UNIT_MUL_EN
            acc      <= 16'h0000;
            cnt      <= 4'd0;
            state    <= (bus.aluk == OP_MUL) ? S_MUL : S_EXEC;
`else
            state    <= S_EXEC;
`endif
          end
        end
        S_EXEC: begin
          bus.result <= alu_y;
          bus.nzp    <= cond_codes(alu_y);
          bus.DR     <= dr_q;
          bus.regWE  <= 1'b1;
          state      <= S_DONE;
        end
`ifdef EXEC_UNIT_MUL_EN
        S_MUL: begin
          acc <= mul_sum;
          a_q <= a_q << 1;
          b_q <= b_q >> 1;
          cnt <= cnt + 4'd1;
          if (cnt == 4'd15) begin
            bus.result <= mul_sum;
            bus.nzp    <= cond_codes(mul_sum);
            bus.DR     <= dr_q;
            bus.regWE  <= 1'b1;
            state      <= S_DONE;
          end
        end
`endif
        S_DONE: begin
          bus.busy <= 1'b0;
          state    <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
